// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    localparam int unsigned N_IN_DEFAULT = 4;

    // Golden response of a 4-input NAND: only vector 4'b1111 drives 0.
    localparam logic [15:0] GOLDEN_NAND4 = 16'h7FFF;

    function automatic int unsigned num_vec(input int unsigned n);
        return 32'd1 << n;
    endfunction

    localparam int unsigned NUM_VEC = num_vec(N_IN_DEFAULT);

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module sweep_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(SETTLE_CYCLES - 1);
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of a small combinational DUT and checks its output
// against a golden truth table.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int unsigned           N_IN          = 4,
    parameter int unsigned           SETTLE_CYCLES = 8,
    parameter logic [(2**N_IN)-1:0]  GOLDEN        = GOLDEN_NAND4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] fail_idx
);

    localparam int unsigned NV = num_vec(N_IN);
    localparam int unsigned EW = N_IN + 1;

    sweep_state_t    state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [EW-1:0]   err_q, err_d;
    logic            fv_q, fv_d;
    logic [N_IN-1:0] fidx_q, fidx_d;

    logic timer_load;
    logic timer_en;
    logic timer_zero;
    logic mismatch;

    sweep_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (timer_load),
        .en   (timer_en),
        .zero (timer_zero)
    );

    assign mismatch = (dut_out != GOLDEN[idx_q]);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        fv_d       = fv_q;
        fidx_d     = fidx_q;
        timer_load = 1'b0;
        timer_en   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            err_d   = '0;
            fv_d    = 1'b0;
            fidx_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        idx_d      = '0;
                        err_d      = '0;
                        fv_d       = 1'b0;
                        fidx_d     = '0;
                        timer_load = 1'b1;
                        state_d    = SETTLE;
                    end
                end
                SETTLE: begin
                    if (timer_zero) begin
                        state_d = SAMPLE;
                    end else begin
                        timer_en = 1'b1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        if (err_q != EW'(NV)) begin
                            err_d = err_q + EW'(1);
                        end
                        if (!fv_q) begin
                            fv_d   = 1'b1;
                            fidx_d = idx_q;
                        end
                    end
                    // The last vector stays applied in DONE; idx never wraps.
                    if (idx_q == N_IN'(NV - 1)) begin
                        state_d = DONE;
                    end else begin
                        idx_d      = idx_q + N_IN'(1);
                        timer_load = 1'b1;
                        state_d    = SETTLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fidx_q  <= fidx_d;
        end
    end

    // dut_in is the registered index, so it only moves on the vector edge.
    assign dut_in     = idx_q;
    assign busy       = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == '0);
    assign err_count  = err_q;
    assign fail_valid = fv_q;
    assign fail_idx   = fidx_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: default build plus a SETTLE_CYCLES=1 build.
module tb_truth_table_sweeper;

    logic clk;
    logic rst_n;
    logic start0, abort0, start1, abort1;
    logic dut_out0, dut_out1;
    logic [3:0] dut_in0, dut_in1, fidx0, fidx1;
    logic [4:0] err0, err1;
    logic busy0, done0, pass0, fv0;
    logic busy1, done1, pass1, fv1;

    int mode;
    int sel;
    int checks;
    int failures;

    logic [3:0] o_dut_in, o_fidx;
    logic [4:0] o_err;
    logic       o_busy, o_done, o_pass, o_fv;

    // Model DUTs: 0 = NAND4, 1 = AND4, 2 = NAND4 with output wrong at 4'b1010.
    function automatic logic model(input int m, input logic [3:0] x);
        logic nand4;
        nand4 = ~&x;
        if (m == 1) return &x;
        if (m == 2 && x == 4'b1010) return ~nand4;
        return nand4;
    endfunction

    assign dut_out0 = model(mode, dut_in0);
    assign dut_out1 = model(mode, dut_in1);

    truth_table_sweeper u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start0),
        .abort     (abort0),
        .dut_out   (dut_out0),
        .dut_in    (dut_in0),
        .busy      (busy0),
        .done      (done0),
        .pass      (pass0),
        .err_count (err0),
        .fail_valid(fv0),
        .fail_idx  (fidx0)
    );

    truth_table_sweeper #(
        .SETTLE_CYCLES(1)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .abort     (abort1),
        .dut_out   (dut_out1),
        .dut_in    (dut_in1),
        .busy      (busy1),
        .done      (done1),
        .pass      (pass1),
        .err_count (err1),
        .fail_valid(fv1),
        .fail_idx  (fidx1)
    );

    always_comb begin
        o_dut_in = (sel != 0) ? dut_in1 : dut_in0;
        o_fidx   = (sel != 0) ? fidx1 : fidx0;
        o_err    = (sel != 0) ? err1 : err0;
        o_busy   = (sel != 0) ? busy1 : busy0;
        o_done   = (sel != 0) ? done1 : done0;
        o_pass   = (sel != 0) ? pass1 : pass0;
        o_fv     = (sel != 0) ? fv1 : fv0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Full sweep on instance s with model m; optional extra start pulse after edge busy_k.
    task automatic do_sweep(input int m, input int s, input int exp_err, input int exp_fidx,
                            input logic exp_fv, input int busy_k, input string tag);
        int per, total, k, done_at, bad;
        mode = m;
        sel  = s;
        per  = (s != 0) ? 2 : 9;
        total = 16 * per;
        @(negedge clk);
        if (s != 0) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clk);
        k = 0;
        done_at = -1;
        bad = -1;
        forever begin
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            if (o_done && done_at < 0) done_at = k;
            if (done_at < 0 && bad < 0 && o_dut_in !== 4'(k / per)) bad = k;
            if (done_at >= 0 || k > total + 20) break;
            if (k == busy_k) begin
                if (s != 0) start1 = 1'b1; else start0 = 1'b1;
            end
            k++;
        end
        checks++;
        if (done_at != total) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected %0d", tag, done_at, total);
        end
        checks++;
        if (bad != -1) begin
            failures++;
            $display("FAIL %s dut_in_seq: wrong at cycle %0d, got %0d expected %0d", tag, bad,
                     o_dut_in, bad / per);
        end
        checks++;
        if (o_err !== 5'(exp_err)) begin
            failures++;
            $display("FAIL %s err_count: got %0d expected %0d", tag, o_err, exp_err);
        end
        checks++;
        if (o_fv !== exp_fv || o_fidx !== 4'(exp_fidx)) begin
            failures++;
            $display("FAIL %s fail_valid/idx: got %b/%0d expected %b/%0d", tag, o_fv, o_fidx,
                     exp_fv, exp_fidx);
        end
        checks++;
        if (o_pass !== (exp_err == 0) || o_busy !== 1'b0 || o_dut_in !== 4'hF) begin
            failures++;
            $display("FAIL %s pass/busy/dut_in: got %b/%b/%h expected %b/0/f", tag, o_pass,
                     o_busy, o_dut_in, exp_err == 0);
        end
    endtask

    // Run instance 0 from a start pulse to the negedge after edge n.
    task automatic start_and_wait(input int n);
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if ({dut_in0, busy0, done0, pass0, err0, fv0, fidx0} !== '0 ||
            {dut_in1, busy1, done1, pass1, err1, fv1, fidx1} !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h / %h expected 0", {dut_in0, busy0, done0, pass0,
                     err0, fv0, fidx0}, {dut_in1, busy1, done1, pass1, err1, fv1, fidx1});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_abort();
        sel  = 0;
        mode = 1;
        start_and_wait(49);
        checks++;
        if (err0 !== 5'd5 || busy0 !== 1'b1) begin
            failures++;
            $display("FAIL abort_pre err/busy: got %0d/%b expected 5/1", err0, busy0);
        end
        abort0 = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        start0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || done0 !== 1'b0 || dut_in0 !== 4'h0 || err0 !== 5'd0 ||
            fv0 !== 1'b0 || fidx0 !== 4'h0) begin
            failures++;
            $display("FAIL abort_post busy/done/dut_in/err/fv/fidx: got %b/%b/%h/%0d/%b/%0d expected 0/0/0/0/0/0",
                     busy0, done0, dut_in0, err0, fv0, fidx0);
        end
        do_sweep(0, 0, 0, 0, 1'b0, -1, "after_abort");
    endtask

    task automatic test_reset_mid();
        sel  = 0;
        mode = 1;
        start_and_wait(70);
        checks++;
        if (err0 !== 5'd7 || fv0 !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre err/fv: got %0d/%b expected 7/1", err0, fv0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dut_in0, busy0, done0, pass0, err0, fv0, fidx0} !== '0) begin
            failures++;
            $display("FAIL rstmid_async: got %h expected 0", {dut_in0, busy0, done0, pass0,
                     err0, fv0, fidx0});
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_sweep(0, 0, 0, 0, 1'b0, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        int k;
        do_sweep(1, 0, 16, 0, 1'b1, 19, "busy_start");
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checks++;
        if (done0 !== 1'b0 || busy0 !== 1'b1 || dut_in0 !== 4'h0 || err0 !== 5'd0 ||
            fv0 !== 1'b0) begin
            failures++;
            $display("FAIL restart done/busy/dut_in/err/fv: got %b/%b/%h/%0d/%b expected 0/1/0/0/0",
                     done0, busy0, dut_in0, err0, fv0);
        end
        k = 0;
        while (!done0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 144 || err0 !== 5'd16) begin
            failures++;
            $display("FAIL restart_complete cycles/err: got %0d/%0d expected 144/16", k, err0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mode     = 0;
        sel      = 0;
        start0   = 1'b0;
        abort0   = 1'b0;
        start1   = 1'b0;
        abort1   = 1'b0;
        test_reset();
        do_sweep(0, 0, 0, 0, 1'b0, -1, "match_nand4");
        do_sweep(1, 0, 16, 0, 1'b1, -1, "faulty_and4");
        do_sweep(2, 0, 1, 10, 1'b1, -1, "stuck_1010");
        test_abort();
        test_reset_mid();
        test_back_to_back();
        do_sweep(0, 1, 0, 0, 1'b0, -1, "settle1_match");
        do_sweep(2, 1, 1, 10, 1'b1, -1, "settle1_stuck");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
